// File: rtl/pmod_ssd_capture.sv
// Receive side of the PMOD SSD link: synchronises the segment/select lines, decodes each
// digit glyph back to a nibble and rebuilds the displayed byte. Option: PMOD_SSD_CAPTURE_CHANGE_ONLY_EN.
module pmod_ssd_capture #(
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 131072
) (
   input  logic       i_clock_125MHz,
   input  logic       i_reset_n,
   input  logic       i_seg_a,
   input  logic       i_seg_b,
   input  logic       i_seg_c,
   input  logic       i_seg_d,
   input  logic       i_seg_e,
   input  logic       i_seg_f,
   input  logic       i_seg_g,
   input  logic       i_seg_sel,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_error,
   output logic       o_stale
);

   localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SCW-1:0] SETTLE_LAST = SCW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 2 : 0);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TCW-1:0] TIMEOUT_MAX = TCW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE} state_t;

   logic [7:0]     raw_in;
   logic [7:0]     meta_q;
   logic [7:0]     sync_q;
   logic           sel_dly;
   logic           sel_now;
   logic           sel_edge;
   logic [6:0]     pattern;
   logic [4:0]     glyph;
   logic           glyph_ok;
   logic [3:0]     nibble;
   logic [TCW-1:0] stale_cnt;
   logic [TCW-1:0] stale_next;
   state_t         state;
   logic [SCW-1:0] settle_cnt;
   logic [3:0]     lo_nib;
   logic           lo_ok;
`ifdef PMOD_SSD_CAPTURE_CHANGE_ONLY_EN
   logic           captured_once;
`endif

   // Returns {legal, nibble} for a {g,f,e,d,c,b,a} segment pattern.
   function automatic logic [4:0] decode_glyph(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h3F:   r = {1'b1, 4'h0};
         7'h06:   r = {1'b1, 4'h1};
         7'h5B:   r = {1'b1, 4'h2};
         7'h4F:   r = {1'b1, 4'h3};
         7'h66:   r = {1'b1, 4'h4};
         7'h6D:   r = {1'b1, 4'h5};
         7'h7D:   r = {1'b1, 4'h6};
         7'h07:   r = {1'b1, 4'h7};
         7'h7F:   r = {1'b1, 4'h8};
         7'h6F:   r = {1'b1, 4'h9};
         7'h77:   r = {1'b1, 4'hA};
         7'h7C:   r = {1'b1, 4'hB};
         7'h39:   r = {1'b1, 4'hC};
         7'h5E:   r = {1'b1, 4'hD};
         7'h79:   r = {1'b1, 4'hE};
         7'h71:   r = {1'b1, 4'hF};
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   assign raw_in   = {i_seg_sel, i_seg_g, i_seg_f, i_seg_e, i_seg_d, i_seg_c, i_seg_b, i_seg_a};
   assign sel_now  = sync_q[7];
   assign pattern  = sync_q[6:0];
   assign sel_edge = sel_now ^ sel_dly;
   assign glyph    = decode_glyph(pattern);
   assign glyph_ok = glyph[4];
   assign nibble   = glyph[3:0];

   always_ff @(posedge i_clock_125MHz or negedge i_reset_n) begin
      if (!i_reset_n) begin
         meta_q  <= '0;
         sync_q  <= '0;
         sel_dly <= 1'b0;
      end else begin
         meta_q  <= raw_in;
         sync_q  <= meta_q;
         sel_dly <= sync_q[7];
      end
   end

   // Saturating idle counter; o_stale follows the next count so it drops right after an edge.
   always_comb begin
      stale_next = stale_cnt;
      if (sel_edge)
         stale_next = '0;
      else if (stale_cnt != TIMEOUT_MAX)
         stale_next = stale_cnt + 1'b1;
   end

   always_ff @(posedge i_clock_125MHz or negedge i_reset_n) begin
      if (!i_reset_n) begin
         stale_cnt <= TIMEOUT_MAX;
         o_stale   <= 1'b1;
      end else begin
         stale_cnt <= stale_next;
         o_stale   <= (stale_next == TIMEOUT_MAX);
      end
   end

   // Any select edge restarts settling, so a sample never lands on a glitching bus.
   always_ff @(posedge i_clock_125MHz or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= IDLE;
         settle_cnt    <= '0;
         lo_nib        <= 4'h0;
         lo_ok         <= 1'b0;
         o_data        <= 8'h00;
         o_valid       <= 1'b0;
         o_error       <= 1'b0;
`ifdef PMOD_SSD_CAPTURE_CHANGE_ONLY_EN
         captured_once <= 1'b0;
`endif
      end else begin
         o_valid <= 1'b0;
         o_error <= 1'b0;
         if (sel_edge) begin
            settle_cnt <= '0;
            state      <= (SETTLE_CYCLES == 1) ? SAMPLE : SETTLE;
         end else begin
            case (state)
               IDLE: begin
               end
               SETTLE: begin
                  if (settle_cnt == SETTLE_LAST)
                     state <= SAMPLE;
                  else
                     settle_cnt <= settle_cnt + 1'b1;
               end
               SAMPLE: begin
                  state <= IDLE;
                  if (!glyph_ok) begin
                     o_error <= 1'b1;
                     lo_ok   <= 1'b0;
                  end else if (!sel_now) begin
                     lo_nib <= nibble;
                     lo_ok  <= 1'b1;
                  end else if (lo_ok) begin
                     lo_ok <= 1'b0;
`ifdef PMOD_SSD_CAPTURE_CHANGE_ONLY_EN
                     captured_once <= 1'b1;
                     if (!captured_once || ({nibble, lo_nib} != o_data)) begin
                        o_data  <= {nibble, lo_nib};
                        o_valid <= 1'b1;
                     end
`else
                     o_data  <= {nibble, lo_nib};
                     o_valid <= 1'b1;
`endif
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pmod_ssd_capture.sv
// Directed bench for pmod_ssd_capture: frames of glyphs on the segment lines with
// hand-computed captured bytes, pulse counts, latency and stale behaviour.
module tb_pmod_ssd_capture;

   localparam int SETTLE  = 8;
   localparam int TIMEOUT = 200;
   localparam int DWELL   = 20;

   logic       clock;
   logic       rst_n;
   logic [6:0] seg;
   logic       sel;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_error;
   logic       o_stale;

   int compare_count  = 0;
   int mismatch_count = 0;
   int valid_count    = 0;
   int error_count    = 0;
   int v0;
   int e0;

   pmod_ssd_capture #(
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .i_clock_125MHz(clock),
      .i_reset_n     (rst_n),
      .i_seg_a       (seg[0]),
      .i_seg_b       (seg[1]),
      .i_seg_c       (seg[2]),
      .i_seg_d       (seg[3]),
      .i_seg_e       (seg[4]),
      .i_seg_f       (seg[5]),
      .i_seg_g       (seg[6]),
      .i_seg_sel     (sel),
      .o_data        (o_data),
      .o_valid       (o_valid),
      .o_error       (o_error),
      .o_stale       (o_stale)
   );

   initial clock = 1'b0;
   always #4 clock = ~clock;

   // Count output pulses mid-cycle so totals can be compared per scenario.
   always @(negedge clock) begin
      if (rst_n && o_valid) valid_count <= valid_count + 1;
      if (rst_n && o_error) error_count <= error_count + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compare_count = compare_count + 1;
      if (observed !== expected) begin
         mismatch_count = mismatch_count + 1;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [6:0] p);
      sel = s;
      seg = p;
   endtask

   task automatic stepCycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b1, 7'h3F);
      stepCycles(3);
      checkOutput("reset_data", {24'h0, o_data}, 32'h00);
      checkOutput("reset_valid", {31'h0, o_valid}, 32'h0);
      checkOutput("reset_error", {31'h0, o_error}, 32'h0);
      checkOutput("reset_stale", {31'h0, o_stale}, 32'h1);
      rst_n = 1'b1;
      stepCycles(DWELL);

      $display("[TB] lo=3, hi=A with latency check");
      v0 = valid_count;
      applyStimulus(1'b0, 7'h4F);
      stepCycles(DWELL);
      applyStimulus(1'b1, 7'h77);
      stepCycles(2 + SETTLE);
      checkOutput("t1_valid_early", {31'h0, o_valid}, 32'h0);
      stepCycles(1);
      checkOutput("t1_valid_pulse", {31'h0, o_valid}, 32'h1);
      checkOutput("t1_data", {24'h0, o_data}, 32'hA3);
      stepCycles(1);
      checkOutput("t1_valid_drop", {31'h0, o_valid}, 32'h0);
      stepCycles(DWELL);
      checkOutput("t1_valid_count", valid_count - v0, 32'd1);
      checkOutput("t1_stale_low", {31'h0, o_stale}, 32'h0);

      $display("[TB] illegal lo blocks the following hi");
      v0 = valid_count;
      e0 = error_count;
      applyStimulus(1'b0, 7'h00);
      stepCycles(DWELL);
      applyStimulus(1'b1, 7'h66);
      stepCycles(DWELL);
      checkOutput("t2_error_count", error_count - e0, 32'd1);
      checkOutput("t2_valid_count", valid_count - v0, 32'd0);
      checkOutput("t2_data_held", {24'h0, o_data}, 32'hA3);

      $display("[TB] select glitch then hi=1");
      v0 = valid_count;
      e0 = error_count;
      applyStimulus(1'b0, 7'h5B);
      stepCycles(2);
      applyStimulus(1'b1, 7'h5B);
      stepCycles(2);
      applyStimulus(1'b0, 7'h5B);
      stepCycles(DWELL);
      applyStimulus(1'b1, 7'h06);
      stepCycles(DWELL);
      checkOutput("t3_valid_count", valid_count - v0, 32'd1);
      checkOutput("t3_error_count", error_count - e0, 32'd0);
      checkOutput("t3_data", {24'h0, o_data}, 32'h12);

      $display("[TB] three repeated frames of 5C");
      v0 = valid_count;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 7'h39);
         stepCycles(DWELL);
         applyStimulus(1'b1, 7'h6D);
         stepCycles(DWELL);
      end
`ifdef PMOD_SSD_CAPTURE_CHANGE_ONLY_EN
      checkOutput("t5_valid_count", valid_count - v0, 32'd1);
`else
      checkOutput("t5_valid_count", valid_count - v0, 32'd3);
`endif
      checkOutput("t5_data", {24'h0, o_data}, 32'h5C);

      $display("[TB] stuck select then one edge");
      stepCycles(TIMEOUT + 4);
      checkOutput("t4_stale_set", {31'h0, o_stale}, 32'h1);
      applyStimulus(1'b0, 7'h3F);
      stepCycles(2);
      checkOutput("t4_stale_before_edge", {31'h0, o_stale}, 32'h1);
      stepCycles(1);
      checkOutput("t4_stale_cleared", {31'h0, o_stale}, 32'h0);
      stepCycles(DWELL);

      $display("[TB] reset during settle after a valid lo");
      v0 = valid_count;
      e0 = error_count;
      applyStimulus(1'b1, 7'h7F);
      stepCycles(5);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_data", {24'h0, o_data}, 32'h00);
      checkOutput("t6_valid", {31'h0, o_valid}, 32'h0);
      checkOutput("t6_error", {31'h0, o_error}, 32'h0);
      checkOutput("t6_stale", {31'h0, o_stale}, 32'h1);
      stepCycles(2);
      rst_n = 1'b1;
      stepCycles(DWELL);
      checkOutput("t6_no_valid_after", valid_count - v0, 32'd0);
      checkOutput("t6_no_error_after", error_count - e0, 32'd0);
      checkOutput("t6_data_after", {24'h0, o_data}, 32'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule
